ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port data RAM (1024 x 32-bit words) between two requesters: master 0 (CPU memory stage) and master 1 (debug/loader port).
- Sits in sopc between the cpu/loader and ram; sequences each access through a 4-state FSM with registered RAM-side outputs and a one-cycle ready pulse per transaction.
- Round-robin grant by default.

Parameters:
ADDRESS_WIDTH, 10, word-address width (1024 words)
DATA_WIDTH, 32, data width; byte select is DATA_WIDTH/8 bits
RAM_LATENCY, 1, cycles from ram_enable to valid ram_read_data; legal range 1..15

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
m0_request  input  1  master 0 access request, held until m0_ready
m0_write  input  1  1 = write, 0 = read
m0_address  input  ADDRESS_WIDTH  word address
m0_write_data  input  DATA_WIDTH  write data
m0_byte_select  input  DATA_WIDTH/8  byte enables for writes
m0_ready  output  1  one-cycle completion pulse
m0_read_data  output  DATA_WIDTH  read result, valid while m0_ready=1
m1_request, m1_write, m1_address, m1_write_data, m1_byte_select, m1_ready, m1_read_data  same as m0 for master 1
ram_enable  output  1  RAM access strobe, one cycle per transaction
ram_write  output  1  RAM write enable
ram_address  output  ADDRESS_WIDTH  RAM address
ram_write_data  output  DATA_WIDTH  RAM write data
ram_byte_select  output  DATA_WIDTH/8  RAM byte enables
ram_read_data  input  DATA_WIDTH  RAM read data
grant_owner  output  1  master currently owning the RAM (valid while busy=1)
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; all outputs 0; latency counter 0; round-robin pointer favours master 0.
- States: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that master.
  - Both requests: grant the master favoured by the pointer.
  - On grant, latch owner, write, address, write data and byte select; go to ISSUE.
- ISSUE (1 cycle):
  - ram_enable=1; ram_write, ram_address, ram_write_data, ram_byte_select driven from the latched values.
  - Counter loads RAM_LATENCY; go to WAIT.
- WAIT (RAM_LATENCY cycles):
  - RAM outputs all 0.
  - On the edge ending the last WAIT cycle: for a read, capture ram_read_data into the owner's read_data register; go to RESPOND.
- RESPOND (1 cycle):
  - Owner's ready=1; the other master's ready=0.
  - Pointer toggles to favour the non-owner.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle N -> ram_enable at N+1 -> ready at N+2+RAM_LATENCY.
- Throughput: one transaction per 3+RAM_LATENCY cycles.
- Read data:
  - mX_read_data updates only on reads by master X; holds its value otherwise, including across writes and the other master's accesses.
  - Writes still pulse ready.
- All outputs are registered; no combinational path from a request to RAM or ready.
- Request dropped mid-transaction: the access still completes and ready still pulses. Requesters must deassert request on the edge where ready=1.
- Request changes on master inputs after grant: ignored; the latched values are used.
- Reset asserted mid-transaction: access aborted, all outputs 0 immediately; no ready pulse after reset release.

Optional Feature:
- Macro: RAM_ARBITER_FIXED_PRIORITY_EN.
- Defined: master 0 always wins simultaneous requests; pointer unused. Master 1 can starve (intended for CPU-critical builds).
- Undefined: round-robin as specified above.

Test Plan:
- Reset: hold reset=0, drive both requests=1 -> all outputs 0, busy=0; after release with no requests, FSM stays IDLE.
- Single read, RAM_LATENCY=1: RAM word 5 = 0xDEADBEEF; m0 read of address 5 at cycle 0 -> ram_enable=1 and ram_address=5 at cycle 1; m0_ready=1 and m0_read_data=0xDEADBEEF at cycle 3; m1_ready stays 0.
- Write then read: m1 writes 0x12345678 to address 1023 with byte_select=0xF -> ram_write=1 in ISSUE; ready pulses; a following m1 read of address 1023 returns 0x12345678; m0_read_data unchanged.
- Contention: both masters hold requests continuously for 4 transactions -> grants alternate m0, m1, m0, m1.
  - With RAM_ARBITER_FIXED_PRIORITY_EN defined: grants are m0 x4, m1 never granted.
- Latency sweep: RAM_LATENCY=3, m0 read -> ready exactly 5 cycles after request; busy=1 for 5 cycles.
- Reset mid-operation: assert reset during WAIT -> outputs 0 at once; after release, no stale ready pulse and no ram_enable until a new request.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single-port data RAM: IDLE -> ISSUE -> WAIT -> RESPOND, registered outputs.
// Define RAM_ARBITER_FIXED_PRIORITY_EN to make master 0 win every tie instead of round-robin.
module ram_arbiter #(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int RAM_LATENCY   = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      m0_request,
  input  logic                      m0_write,
  input  logic [ADDRESS_WIDTH-1:0]  m0_address,
  input  logic [DATA_WIDTH-1:0]     m0_write_data,
  input  logic [DATA_WIDTH/8-1:0]   m0_byte_select,
  output logic                      m0_ready,
  output logic [DATA_WIDTH-1:0]     m0_read_data,
  input  logic                      m1_request,
  input  logic                      m1_write,
  input  logic [ADDRESS_WIDTH-1:0]  m1_address,
  input  logic [DATA_WIDTH-1:0]     m1_write_data,
  input  logic [DATA_WIDTH/8-1:0]   m1_byte_select,
  output logic                      m1_ready,
  output logic [DATA_WIDTH-1:0]     m1_read_data,
  output logic                      ram_enable,
  output logic                      ram_write,
  output logic [ADDRESS_WIDTH-1:0]  ram_address,
  output logic [DATA_WIDTH-1:0]     ram_write_data,
  output logic [DATA_WIDTH/8-1:0]   ram_byte_select,
  input  logic [DATA_WIDTH-1:0]     ram_read_data,
  output logic                      grant_owner,
  output logic                      busy
);

  localparam int BW = DATA_WIDTH / 8;
  localparam logic [3:0] LATENCY = 4'(RAM_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     owner_q, owner_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [BW-1:0]            bsel_q, bsel_d;

  logic                     ram_enable_q, ram_enable_d;
  logic                     ram_write_q, ram_write_d;
  logic [ADDRESS_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0]    ram_write_data_q, ram_write_data_d;
  logic [BW-1:0]            ram_byte_select_q, ram_byte_select_d;
  logic                     grant_owner_q, grant_owner_d;
  logic                     busy_q, busy_d;
  logic                     m0_ready_q, m0_ready_d;
  logic                     m1_ready_q, m1_ready_d;
  logic [DATA_WIDTH-1:0]    m0_read_data_q, m0_read_data_d;
  logic [DATA_WIDTH-1:0]    m1_read_data_q, m1_read_data_d;

  logic grant_m1;
  logic capture;

`ifdef RAM_ARBITER_FIXED_PRIORITY_EN
  // Master 0 wins every tie; master 1 only gets the RAM when master 0 is quiet
  always_comb begin
    grant_m1 = m1_request & ~m0_request;
  end
`else
  logic rr_q, rr_d;

  // Tie-break pointer: 0 favours master 0; after each transaction it points at the non-owner
  always_comb begin
    grant_m1 = m1_request & (~m0_request | rr_q);
    rr_d     = (state_q == ST_RESPOND) ? ~owner_q : rr_q;
  end

  // Round-robin pointer register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Next-state logic; the request is latched on grant so later master-side changes are ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bsel_d  = bsel_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_request | m1_request) begin
          state_d = ST_ISSUE;
          owner_d = grant_m1;
          write_d = grant_m1 ? m1_write       : m0_write;
          addr_d  = grant_m1 ? m1_address     : m0_address;
          wdata_d = grant_m1 ? m1_write_data  : m0_write_data;
          bsel_d  = grant_m1 ? m1_byte_select : m0_byte_select;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LATENCY;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_RESPOND;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output logic: every output is the registered image of the state being entered
  always_comb begin
    ram_enable_d      = (state_d == ST_ISSUE);
    ram_write_d       = ram_enable_d ? write_d : 1'b0;
    ram_address_d     = ram_enable_d ? addr_d  : {ADDRESS_WIDTH{1'b0}};
    ram_write_data_d  = ram_enable_d ? wdata_d : {DATA_WIDTH{1'b0}};
    ram_byte_select_d = ram_enable_d ? bsel_d  : {BW{1'b0}};
    busy_d            = (state_d != ST_IDLE);
    grant_owner_d     = busy_d ? owner_d : 1'b0;
    m0_ready_d        = (state_d == ST_RESPOND) & ~owner_d;
    m1_ready_d        = (state_d == ST_RESPOND) &  owner_d;
    capture           = (state_q == ST_WAIT) & (state_d == ST_RESPOND) & ~write_q;
    m0_read_data_d    = (capture & ~owner_q) ? ram_read_data : m0_read_data_q;
    m1_read_data_d    = (capture &  owner_q) ? ram_read_data : m1_read_data_q;
  end

  // State, latched request and registered outputs; reset aborts any access in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      cnt_q             <= 4'd0;
      owner_q           <= 1'b0;
      write_q           <= 1'b0;
      addr_q            <= {ADDRESS_WIDTH{1'b0}};
      wdata_q           <= {DATA_WIDTH{1'b0}};
      bsel_q            <= {BW{1'b0}};
      ram_enable_q      <= 1'b0;
      ram_write_q       <= 1'b0;
      ram_address_q     <= {ADDRESS_WIDTH{1'b0}};
      ram_write_data_q  <= {DATA_WIDTH{1'b0}};
      ram_byte_select_q <= {BW{1'b0}};
      grant_owner_q     <= 1'b0;
      busy_q            <= 1'b0;
      m0_ready_q        <= 1'b0;
      m1_ready_q        <= 1'b0;
      m0_read_data_q    <= {DATA_WIDTH{1'b0}};
      m1_read_data_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      owner_q           <= owner_d;
      write_q           <= write_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      bsel_q            <= bsel_d;
      ram_enable_q      <= ram_enable_d;
      ram_write_q       <= ram_write_d;
      ram_address_q     <= ram_address_d;
      ram_write_data_q  <= ram_write_data_d;
      ram_byte_select_q <= ram_byte_select_d;
      grant_owner_q     <= grant_owner_d;
      busy_q            <= busy_d;
      m0_ready_q        <= m0_ready_d;
      m1_ready_q        <= m1_ready_d;
      m0_read_data_q    <= m0_read_data_d;
      m1_read_data_q    <= m1_read_data_d;
    end
  end

  assign ram_enable      = ram_enable_q;
  assign ram_write       = ram_write_q;
  assign ram_address     = ram_address_q;
  assign ram_write_data  = ram_write_data_q;
  assign ram_byte_select = ram_byte_select_q;
  assign grant_owner     = grant_owner_q;
  assign busy            = busy_q;
  assign m0_ready        = m0_ready_q;
  assign m1_ready        = m1_ready_q;
  assign m0_read_data    = m0_read_data_q;
  assign m1_read_data    = m1_read_data_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance at RAM_LATENCY=1 (dut) and one at RAM_LATENCY=3 (dut3).
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_request, m0_write, m1_request, m1_write;
  logic [9:0]  m0_address, m1_address;
  logic [31:0] m0_write_data, m1_write_data;
  logic [3:0]  m0_byte_select, m1_byte_select;

  logic        m0_ready, m1_ready, ram_enable, ram_write, grant_owner, busy;
  logic [31:0] m0_read_data, m1_read_data, ram_write_data;
  logic [31:0] rd1 = 32'd0;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byte_select;

  logic        r3_request;
  logic        c_m0_ready, c_m1_ready, c_ram_enable, c_ram_write, c_grant_owner, c_busy;
  logic [31:0] c_m0_read_data, c_m1_read_data, c_ram_write_data;
  logic [31:0] p0 = 32'd0, p1 = 32'd0, p2 = 32'd0;
  logic [9:0]  c_ram_address;
  logic [3:0]  c_ram_byte_select;

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem3 [0:1023];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .RAM_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .m0_request(m0_request), .m0_write(m0_write), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_byte_select(m0_byte_select),
    .m0_ready(m0_ready), .m0_read_data(m0_read_data),
    .m1_request(m1_request), .m1_write(m1_write), .m1_address(m1_address),
    .m1_write_data(m1_write_data), .m1_byte_select(m1_byte_select),
    .m1_ready(m1_ready), .m1_read_data(m1_read_data),
    .ram_enable(ram_enable), .ram_write(ram_write), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_byte_select(ram_byte_select),
    .ram_read_data(rd1), .grant_owner(grant_owner), .busy(busy)
  );

  ram_arbiter #(.ADDRESS_WIDTH(10), .DATA_WIDTH(32), .RAM_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .m0_request(r3_request), .m0_write(m0_write), .m0_address(m0_address),
    .m0_write_data(m0_write_data), .m0_byte_select(m0_byte_select),
    .m0_ready(c_m0_ready), .m0_read_data(c_m0_read_data),
    .m1_request(1'b0), .m1_write(1'b0), .m1_address(10'd0),
    .m1_write_data(32'd0), .m1_byte_select(4'd0),
    .m1_ready(c_m1_ready), .m1_read_data(c_m1_read_data),
    .ram_enable(c_ram_enable), .ram_write(c_ram_write), .ram_address(c_ram_address),
    .ram_write_data(c_ram_write_data), .ram_byte_select(c_ram_byte_select),
    .ram_read_data(p2), .grant_owner(c_grant_owner), .busy(c_busy)
  );

  // Latency-1 RAM model with byte-enabled writes
  always @(posedge clock) begin
    if (ram_enable) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byte_select[b]) mem1[ram_address][8*b +: 8] <= ram_write_data[8*b +: 8];
      end else begin
        rd1 <= mem1[ram_address];
      end
    end
  end

  // Latency-3 RAM model: read data passes through a three-stage pipe
  always @(posedge clock) begin
    p1 <= p0;
    p2 <= p1;
    if (c_ram_enable) begin
      if (c_ram_write) begin
        for (int b = 0; b < 4; b++)
          if (c_ram_byte_select[b]) mem3[c_ram_address][8*b +: 8] <= c_ram_write_data[8*b +: 8];
      end else begin
        p0 <= mem3[c_ram_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for either dut ready; reports cycles elapsed and which master finished
  task automatic wait_done(output int cyc, output logic who);
    cyc = 0;
    who = 1'b0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (m0_ready | m1_ready) begin
        who = m1_ready;
        return;
      end
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  logic exp_grant [0:3];
  int   cyc;
  logic who;
  int   busy_cnt, rdy_at;
  logic seen;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    mem1[5] = 32'hDEADBEEF;
    mem3[7] = 32'hA5A50003;
`ifdef RAM_ARBITER_FIXED_PRIORITY_EN
    exp_grant = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_grant = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif

    reset = 1'b0;
    m0_request = 1'b1; m0_write = 1'b0; m0_address = 10'd0; m0_write_data = 32'd0; m0_byte_select = 4'd0;
    m1_request = 1'b1; m1_write = 1'b0; m1_address = 10'd0; m1_write_data = 32'd0; m1_byte_select = 4'd0;
    r3_request = 1'b1;
    repeat (3) tick();
    check("rst_ctrl", {26'd0, ram_enable, ram_write, busy, grant_owner, m0_ready, m1_ready}, 32'd0);
    check("rst_m0_rdata", m0_read_data, 32'd0);
    check("rst_busy3", {31'd0, c_busy | c_ram_enable}, 32'd0);
    m0_request = 1'b0; m1_request = 1'b0; r3_request = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("idle_after_rst", {30'd0, busy, ram_enable}, 32'd0);

    // Single m0 read of word 5, latency 1
    m0_request = 1'b1; m0_write = 1'b0; m0_address = 10'd5;
    tick();
    check("rd_issue", {20'd0, ram_enable, ram_write, ram_address}, {20'd0, 1'b1, 1'b0, 10'd5});
    check("rd_owner_busy", {30'd0, grant_owner, busy}, 32'd1);
    tick();
    check("rd_wait_en", {31'd0, ram_enable}, 32'd0);
    tick();
    check("rd_ready", {30'd0, m0_ready, m1_ready}, 32'd2);
    check("rd_data", m0_read_data, 32'hDEADBEEF);
    m0_request = 1'b0;
    tick();
    check("rd_pulse_end", {31'd0, m0_ready}, 32'd0);
    check("rd_hold", m0_read_data, 32'hDEADBEEF);

    // m1 write to 1023, inputs disturbed after grant, then read back
    m1_request = 1'b1; m1_write = 1'b1; m1_address = 10'd1023;
    m1_write_data = 32'h12345678; m1_byte_select = 4'hF;
    tick();
    check("wr_issue", {20'd0, ram_write, grant_owner, ram_address}, {20'd0, 1'b1, 1'b1, 10'd1023});
    check("wr_data", ram_write_data, 32'h12345678);
    check("wr_bsel", {28'd0, ram_byte_select}, 32'hF);
    m1_address = 10'd0; m1_write_data = 32'd0;
    wait_done(cyc, who);
    check("wr_ready_cyc", cyc, 32'd2);
    check("wr_ready_who", {31'd0, who}, 32'd1);
    m1_request = 1'b0; m1_write = 1'b0; m1_address = 10'd1023;
    tick();
    check("wr_mem", mem1[1023], 32'h12345678);
    m1_request = 1'b1;
    wait_done(cyc, who);
    check("rb_cyc", cyc, 32'd3);
    check("rb_data", m1_read_data, 32'h12345678);
    check("rb_m0_hold", m0_read_data, 32'hDEADBEEF);
    m1_request = 1'b0;
    tick();

    // Contention: both masters request continuously for four transactions
    m0_request = 1'b1; m1_request = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wait_done(cyc, who);
      check($sformatf("grant%0d", t), {31'd0, who}, {31'd0, exp_grant[t]});
    end
    m0_request = 1'b0; m1_request = 1'b0;
    tick();

    // Latency sweep on the RAM_LATENCY=3 instance
    r3_request = 1'b1; m0_write = 1'b0; m0_address = 10'd7;
    busy_cnt = 0; rdy_at = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (c_busy) busy_cnt++;
      if (c_m0_ready && rdy_at == 0) begin
        rdy_at = k;
        r3_request = 1'b0;
        check("lat3_data", c_m0_read_data, 32'hA5A50003);
      end
    end
    check("lat3_ready_at", rdy_at, 32'd5);
    check("lat3_busy_cnt", busy_cnt, 32'd5);

    // Reset during WAIT of an m1 read
    m1_request = 1'b1; m1_write = 1'b0; m1_address = 10'd1023;
    tick();
    tick();
    check("mid_in_wait", {30'd0, busy, grant_owner}, 32'd3);
    reset = 1'b0; m1_request = 1'b0;
    #1;
    check("mid_rst_ctrl", {29'd0, busy, grant_owner, ram_enable}, 32'd0);
    check("mid_rst_rdata", m1_read_data, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | m0_ready | m1_ready | ram_enable | busy;
    end
    check("no_stale", {31'd0, seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
